// File: rtl/scandoubler_ctrl.sv
// Scan-doubler timing controller: measures input line geometry on ce_x1, schedules
// the two-bank line buffer and regenerates doubled-rate sync on ce_x2.
module scandoubler_ctrl #(
  parameter int HBITS      = 10,
  parameter int LOCK_LINES = 2
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ce_x1,
  input  logic             ce_x2,
  input  logic             hs_in,
  input  logic             vs_in,
  output logic             wr_en,
  output logic [HBITS:0]   wr_addr,
  output logic [HBITS:0]   rd_addr,
  output logic             hs_out,
  output logic             vs_out,
  output logic             scanline,
  output logic             locked
);

  localparam int              LCW    = $clog2(LOCK_LINES + 1);
  localparam logic [HBITS-1:0] HMAX   = {HBITS{1'b1}};
  localparam logic [LCW-1:0]   LOCK_N = LCW'(LOCK_LINES);

  logic [HBITS-1:0] hcnt_r;
  logic [HBITS-1:0] hs_max_r;
  logic [HBITS-1:0] hs_rise_r;
  logic [HBITS-1:0] ocnt_r;
  logic [LCW-1:0]   lock_cnt_r;
  logic [LCW-1:0]   lock_cnt_nxt_s;
  logic             locked_nxt_s;
  logic             wr_bank_r;
  logic             hs_d_r;
  logic             vs_d_r;
  logic             vs_lat_r;
  logic             hs2_d_r;
  logic             first_r;

  logic line_start_s;
  logic hs_rise_edge_s;
  logic vs_edge_s;
  logic len_match_s;
  logic resync_s;

  assign line_start_s   = ce_x1 & hs_d_r & ~hs_in;
  assign hs_rise_edge_s = ce_x1 & ~hs_d_r & hs_in;
  assign vs_edge_s      = ce_x1 & (vs_d_r ^ vs_in);
  assign len_match_s    = (hcnt_r == hs_max_r);
  assign resync_s       = hs2_d_r & ~hs_in;

  assign wr_en   = ce_x1 & ~reset;
  assign wr_addr = {wr_bank_r, hcnt_r};

  // Lock tracking: consecutive equal line lengths; a saturated line breaks the run
  always_comb begin
    lock_cnt_nxt_s = lock_cnt_r;
    locked_nxt_s   = locked;
    if (line_start_s) begin
      if (len_match_s) begin
        if (lock_cnt_r < LOCK_N) begin
          lock_cnt_nxt_s = lock_cnt_r + 1'b1;
        end else begin
          lock_cnt_nxt_s = lock_cnt_r;
        end
        locked_nxt_s = (lock_cnt_nxt_s >= LOCK_N);
      end else begin
        lock_cnt_nxt_s = '0;
        locked_nxt_s   = 1'b0;
      end
    end else if (ce_x1 && (hcnt_r == HMAX)) begin
      lock_cnt_nxt_s = '0;
      locked_nxt_s   = 1'b0;
    end else begin
      lock_cnt_nxt_s = lock_cnt_r;
      locked_nxt_s   = locked;
    end
  end

  // Input side: pixel counter, line measurement and write-bank selection
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hcnt_r     <= '0;
      hs_max_r   <= '0;
      hs_rise_r  <= '0;
      wr_bank_r  <= 1'b0;
      hs_d_r     <= 1'b0;
      vs_d_r     <= 1'b0;
      vs_lat_r   <= 1'b0;
      lock_cnt_r <= '0;
      locked     <= 1'b0;
    end else if (ce_x1) begin
      hs_d_r     <= hs_in;
      vs_d_r     <= vs_in;
      lock_cnt_r <= lock_cnt_nxt_s;
      locked     <= locked_nxt_s;
      if (line_start_s) begin
        hs_max_r <= hcnt_r;
        hcnt_r   <= '0;
        vs_lat_r <= vs_in;
      end else if (hcnt_r != HMAX) begin
        hcnt_r <= hcnt_r + 1'b1;
      end
      if (hs_rise_edge_s) begin
        hs_rise_r <= hcnt_r;
      end
      // a frame boundary realigns banks even if a line also starts now
      if (vs_edge_s) begin
        wr_bank_r <= 1'b0;
      end else if (line_start_s) begin
        wr_bank_r <= ~wr_bank_r;
      end
    end
  end

  // Output side: doubled-rate counter, sync regeneration and read addressing
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ocnt_r   <= '0;
      hs2_d_r  <= 1'b0;
      first_r  <= 1'b0;
      rd_addr  <= '0;
      hs_out   <= 1'b0;
      vs_out   <= 1'b0;
      scanline <= 1'b0;
    end else begin
      if (ce_x2) begin
        hs2_d_r <= hs_in;
        rd_addr <= {~wr_bank_r, ocnt_r};
        if (ocnt_r == hs_max_r) begin
          ocnt_r   <= '0;
          hs_out   <= 1'b0;
          vs_out   <= vs_lat_r;
          first_r  <= 1'b0;
          scanline <= first_r ? 1'b0 : ~scanline;
        end else begin
          ocnt_r <= resync_s ? hs_max_r : ocnt_r + 1'b1;
          if (ocnt_r == hs_rise_r) begin
            hs_out <= 1'b1;
          end
          // after a resync load the next wrap starts the first copy
          if (resync_s) begin
            first_r <= 1'b1;
          end
        end
      end
      if (vs_edge_s) begin
        scanline <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_scandoubler_ctrl.sv
// Self-checking bench for scandoubler_ctrl: directed line tables, corner sequences
// and randomized traffic compared every cycle against a line-level reference model.
module tb_scandoubler_ctrl;

  localparam int HBITS = 10;
  localparam int LOCK  = 2;
  localparam int HMAX  = 1023;

  logic        clk = 1'b0;
  logic        reset, ce_x1, ce_x2, hs_in, vs_in;
  logic        wr_en, hs_out, vs_out, scanline, locked;
  logic [10:0] wr_addr, rd_addr;

  always #5 clk = ~clk;

  scandoubler_ctrl #(.HBITS(HBITS), .LOCK_LINES(LOCK)) dut (
    .clk_sys(clk), .reset(reset), .ce_x1(ce_x1), .ce_x2(ce_x2),
    .hs_in(hs_in), .vs_in(vs_in), .wr_en(wr_en), .wr_addr(wr_addr),
    .rd_addr(rd_addr), .hs_out(hs_out), .vs_out(vs_out),
    .scanline(scanline), .locked(locked)
  );

  int tests = 0;
  int fails = 0;
  int hs_high_cnt = 0;

  // reference state; hs_max is the last recorded line length
  int m_hcnt, m_hs_rise, m_ocnt, m_rd;
  bit m_bank, m_hs_d, m_vs_d, m_vs_lat, m_hs2_d, m_first, m_hs_out, m_vs_out, m_scan;
  int hist[$];
  int brk;

  function automatic bit m_locked();
    if (hist.size() - LOCK < brk) return 1'b0;
    for (int k = 0; k < LOCK; k++) begin
      int idx = hist.size() - 1 - k;
      if (hist[idx] != hist[idx-1]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic m_reset();
    m_hcnt = 0; m_hs_rise = 0; m_ocnt = 0; m_rd = 0;
    m_bank = 0; m_hs_d = 0; m_vs_d = 0; m_vs_lat = 0; m_hs2_d = 0;
    m_first = 0; m_hs_out = 0; m_vs_out = 0; m_scan = 0;
    hist.delete(); hist.push_back(0); brk = 1;
  endtask

  task automatic m_step(input bit r, input bit c1, input bit c2, input bit hs, input bit vs);
    int hs_max, o_hcnt, o_ocnt, o_hs_rise;
    bit o_bank, o_hs_d, o_vs_d, o_vs_lat, o_hs2_d, vedge, wrap, fall;
    if (r) begin
      m_reset();
      return;
    end
    hs_max = hist[$]; o_hcnt = m_hcnt; o_ocnt = m_ocnt; o_hs_rise = m_hs_rise;
    o_bank = m_bank; o_hs_d = m_hs_d; o_vs_d = m_vs_d; o_vs_lat = m_vs_lat; o_hs2_d = m_hs2_d;
    vedge = c1 && (o_vs_d != vs);
    if (c1) begin
      if (o_hs_d && !hs) begin
        hist.push_back(o_hcnt);
        m_hcnt = 0; m_bank = !o_bank; m_vs_lat = vs;
      end else if (o_hcnt == HMAX) begin
        brk = hist.size();
      end else begin
        m_hcnt = o_hcnt + 1;
      end
      if (!o_hs_d && hs) m_hs_rise = o_hcnt;
      if (vedge) m_bank = 0;
      m_hs_d = hs; m_vs_d = vs;
    end
    if (c2) begin
      wrap = (o_ocnt == hs_max);
      fall = o_hs2_d && !hs;
      m_rd = o_bank ? o_ocnt : 1024 + o_ocnt;
      if (wrap) begin
        m_ocnt = 0; m_hs_out = 0; m_vs_out = o_vs_lat;
        m_scan = m_first ? 1'b0 : !m_scan; m_first = 0;
      end else begin
        m_ocnt = fall ? hs_max : (o_ocnt + 1) % 1024;
        if (o_ocnt == o_hs_rise) m_hs_out = 1;
        if (fall) m_first = 1;
      end
      m_hs2_d = hs;
    end
    if (vedge) m_scan = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // one clock: drive, compare all outputs with the model mid-cycle, then advance the model
  task automatic tick(input bit r, input bit c1, input bit c2, input bit hs, input bit vs,
                      input bit do_chk);
    logic [26:0] got, exp;
    logic [10:0] wa_e, ra_e;
    @(negedge clk);
    reset = r; ce_x1 = c1; ce_x2 = c2; hs_in = hs; vs_in = vs;
    #1;
    wa_e = {m_bank, 10'(m_hcnt)};
    ra_e = 11'(m_rd);
    exp = {c1 & ~r, wa_e, ra_e, m_hs_out, m_vs_out, m_scan, m_locked()};
    got = {wr_en, wr_addr, rd_addr, hs_out, vs_out, scanline, locked};
    if (c2 && hs_out === 1'b1) hs_high_cnt++;
    if (do_chk) chk("model", 32'(got), 32'(exp));
    @(posedge clk);
    m_step(r, c1, c2, hs, vs);
  endtask

  // one input pixel: ce_x1 with coincident ce_x2, then a lone ce_x2
  task automatic sample(input bit hs, input bit vs);
    tick(1'b0, 1'b1, 1'b1, hs, vs, 1'b1);
    tick(1'b0, 1'b0, 1'b0, hs, vs, 1'b1);
    tick(1'b0, 1'b0, 1'b1, hs, vs, 1'b1);
    tick(1'b0, 1'b0, 1'b0, hs, vs, 1'b1);
  endtask

  typedef struct {
    int len; int low; bit vs0; bit vs1; int vs_at;
    bit exp_locked; bit exp_bank; bit exp_vs_out; int exp_hs_high;
  } rec_t;

  rec_t tbl[13];

  initial begin
    tbl[0]  = '{400, 31, 1'b0, 1'b0,   0, 1'b0, 1'b1, 1'b0,  -1};
    tbl[1]  = '{400, 31, 1'b0, 1'b0,   0, 1'b0, 1'b0, 1'b0,  -1};
    tbl[2]  = '{400, 31, 1'b0, 1'b0,   0, 1'b1, 1'b1, 1'b0,  -1};
    tbl[3]  = '{400, 31, 1'b0, 1'b0,   0, 1'b1, 1'b0, 1'b0, 738};
    tbl[4]  = '{401, 31, 1'b0, 1'b0,   0, 1'b1, 1'b1, 1'b0,  -1};
    tbl[5]  = '{401, 31, 1'b0, 1'b0,   0, 1'b0, 1'b0, 1'b0,  -1};
    tbl[6]  = '{401, 31, 1'b0, 1'b0,   0, 1'b0, 1'b1, 1'b0,  -1};
    tbl[7]  = '{401, 31, 1'b0, 1'b0,   0, 1'b1, 1'b0, 1'b0,  -1};
    tbl[8]  = '{400, 31, 1'b1, 1'b1,   0, 1'b1, 1'b0, 1'b1,  -1};
    tbl[9]  = '{400, 31, 1'b1, 1'b1,   0, 1'b0, 1'b1, 1'b1,  -1};
    tbl[10] = '{400, 31, 1'b1, 1'b1,   0, 1'b0, 1'b0, 1'b1,  -1};
    tbl[11] = '{400, 31, 1'b1, 1'b0, 200, 1'b1, 1'b0, 1'b1,  -1};
    tbl[12] = '{400, 31, 1'b0, 1'b0,   0, 1'b1, 1'b1, 1'b0, 738};

    m_reset();
    reset = 1'b1; ce_x1 = 1'b0; ce_x2 = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    chk("reset_outputs", {27'd0, hs_out, vs_out, scanline, locked, wr_en}, 32'd0);
    chk("reset_wr_addr", 32'(wr_addr), 32'd0);
    chk("reset_rd_addr", 32'(rd_addr), 32'd0);

    // preamble: hsync high so the first table line begins with a falling edge
    for (int s = 0; s < 399; s++) sample(1'b1, 1'b0);

    for (int i = 0; i < 13; i++) begin
      hs_high_cnt = 0;
      for (int s = 0; s < tbl[i].len; s++)
        sample(s >= tbl[i].low, (s >= tbl[i].vs_at) ? tbl[i].vs1 : tbl[i].vs0);
      #2;
      chk($sformatf("line%0d_locked", i), 32'(locked), 32'(tbl[i].exp_locked));
      chk($sformatf("line%0d_wr_bank", i), 32'(wr_addr[10]), 32'(tbl[i].exp_bank));
      chk($sformatf("line%0d_rd_bank", i), 32'(rd_addr[10]), 32'(!tbl[i].exp_bank));
      chk($sformatf("line%0d_vs_out", i), 32'(vs_out), 32'(tbl[i].exp_vs_out));
      if (tbl[i].exp_hs_high >= 0)
        chk($sformatf("line%0d_hs_width", i), 32'(hs_high_cnt), 32'(tbl[i].exp_hs_high));
    end

    // long line without falling edge: counter saturates, lock lost
    for (int s = 0; s < 1100; s++) sample(1'b1, 1'b0);
    #2;
    chk("sat_wr_addr", 32'(wr_addr), 32'h7FF);
    chk("sat_locked", 32'(locked), 32'd0);
    sample(1'b0, 1'b0);
    #2;
    chk("after_sat_wr_addr", 32'(wr_addr), 32'd0);
    for (int s = 0; s < 37; s++) sample(1'b0, 1'b0);

    // one-clock reset mid-line
    tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    #2;
    chk("midreset_wr_en", 32'(wr_en), 32'd0);
    chk("midreset_wr_addr", 32'(wr_addr), 32'd0);
    chk("midreset_rd_addr", 32'(rd_addr), 32'd0);
    chk("midreset_flags", {28'd0, hs_out, vs_out, scanline, locked}, 32'd0);

    // randomized regular lines of varying geometry
    for (int b = 0; b < 30; b++) begin
      int len  = $urandom_range(8, 60);
      int low  = $urandom_range(1, len - 1);
      int rep  = $urandom_range(2, 5);
      bit vsv  = ($urandom_range(0, 1) == 1);
      for (int r = 0; r < rep; r++)
        for (int s = 0; s < len; s++) sample(s >= low, vsv);
    end

    // unconstrained traffic including degenerate lines and stray resets
    begin
      bit hs = 1'b0;
      bit vs = 1'b0;
      for (int t = 0; t < 6000; t++) begin
        bit r  = ($urandom_range(0, 999) == 0);
        bit c2 = ($urandom_range(0, 1) == 1);
        bit c1 = c2 && ($urandom_range(0, 1) == 1);
        if ($urandom_range(0, 15) == 0) hs = !hs;
        if ($urandom_range(0, 399) == 0) vs = !vs;
        tick(r, c1, c2, hs, vs, 1'b1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
